mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants while an instruction request is pending.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be as follows (clock and reset first):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- imem_addr  in  32  fetch address.
- imem_rmask  in  4  fetch byte read mask; nonzero means a fetch request.
- imem_rdata  out  32  fetch data.
- imem_resp  out  1  fetch complete, one-cycle pulse.
- dmem_addr  in  32  load/store address.
- dmem_rmask  in  4  load byte mask.
- dmem_wmask  in  4  store byte mask; data request when rmask or wmask is nonzero.
- dmem_wdata  in  32  store data.
- dmem_rdata  out  32  load data.
- dmem_resp  out  1  data access complete, one-cycle pulse.
- mem_addr  out  32  shared memory address.
- mem_rmask  out  4  shared read mask.
- mem_wmask  out  4  shared write mask.
- mem_wdata  out  32  shared write data.
- mem_rdata  in  32  shared read data.
- mem_resp  in  1  shared memory response.

Function
REQ-004 The block SHALL have three states: IDLE, IBUSY and DBUSY.
REQ-005 Requesters hold their address, mask and data stable from request until their resp; the block SHALL only sample requester inputs in IDLE.
REQ-006 In IDLE with only a data request pending, the block SHALL latch dmem_addr, rmask, wmask and wdata and go to DBUSY.
REQ-007 In IDLE with only a fetch request pending, the block SHALL latch imem_addr and imem_rmask (wmask 0, wdata 0) and go to IBUSY.
REQ-008 In IDLE with both requests pending, the block SHALL grant data, unless the starvation counter equals STARVE_LIMIT, in which case it SHALL grant fetch.
REQ-009 The starvation counter SHALL:
- increment on each data grant made while a fetch request is pending;
- clear on any fetch grant;
- clear on any data grant made with no fetch pending;
- saturate at STARVE_LIMIT.
REQ-010 In IBUSY or DBUSY, mem_addr, mem_rmask, mem_wmask and mem_wdata SHALL be driven from the latched registers and held constant until mem_resp.
REQ-011 In IDLE, mem_rmask, mem_wmask, mem_addr and mem_wdata SHALL all be 0.
REQ-012 Latency SHALL be: request sampled in IDLE at edge N; memory outputs valid from cycle N+1.
REQ-013 In IBUSY with mem_resp=1, imem_resp SHALL be 1 in that same cycle (combinational) and the state SHALL return to IDLE.
REQ-014 In DBUSY with mem_resp=1, dmem_resp SHALL be 1 in that same cycle (combinational) and the state SHALL return to IDLE.
REQ-015 imem_rdata and dmem_rdata SHALL equal mem_rdata at all times; they are valid only when the matching resp is 1.
REQ-016 At most one of imem_resp and dmem_resp SHALL be 1 in any cycle.
REQ-017 A resp SHALL never be asserted outside its owning BUSY state.
REQ-018 mem_resp in IDLE SHALL be ignored, producing no resp and no state change.
REQ-019 After each completion, the block SHALL spend one IDLE cycle before the next grant, so that stale requester inputs are not re-issued.
REQ-020 A data request with both rmask and wmask nonzero SHALL be forwarded unchanged, with no arbitration effect.
REQ-021 Address bits [1:0] SHALL be forwarded unmodified; alignment is the requester's responsibility.

Reset
REQ-022 While rst=0, the block SHALL asynchronously force:
- the state to IDLE and the starvation counter to 0;
- all latched registers to 0;
- mem_rmask, mem_wmask, mem_addr and mem_wdata to 0;
- imem_resp and dmem_resp to 0.
REQ-023 Reset mid-access SHALL abandon the transaction; a late mem_resp arriving after reset release SHALL be ignored per REQ-018.

Verification
REQ-024 Fetch only: imem_addr=0x1eceb000, imem_rmask=0xF; mem_resp=1 with mem_rdata=0x00000013 three cycles later -> mem_rmask=0xF from cycle N+1, imem_resp=1 for one cycle with imem_rdata=0x00000013, dmem_resp=0.
REQ-025 Simultaneous fetch (0x1eceb004) and load (dmem_addr=0x100, dmem_rmask=0x1) -> mem_addr=0x100 first; after dmem_resp, one IDLE cycle, then mem_addr=0x1eceb004 with mem_rmask=0xF.
REQ-026 Store: dmem_addr=0x202, dmem_wmask=0x3, dmem_wdata=0xdeadbeef -> mem_wmask=0x3, mem_rmask=0, mem_wdata=0xdeadbeef held until mem_resp; then dmem_resp pulses once.
REQ-027 Starvation: fetch held pending while back-to-back data requests arrive (STARVE_LIMIT=4) -> four data grants, then the fifth grant is fetch, and the counter reads 0 afterward.
REQ-028 Reset asserted in DBUSY -> mem masks 0 immediately; release reset, then pulse mem_resp -> no dmem_resp, state remains IDLE.
REQ-029 Spurious mem_resp in IDLE with no requests -> imem_resp=dmem_resp=0, all mem outputs remain 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single shared memory port between an instruction-fetch requester
// and a data requester, favouring data but bounding how long fetch can be starved.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   localparam int CW = $clog2(STARVE_LIMIT + 2);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] starve_reg, starve_next;
   logic [31:0]   addr_reg, addr_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic [3:0]    rmask_reg, rmask_next;
   logic [3:0]    wmask_reg, wmask_next;

   logic i_req, d_req, grant_i, grant_d, busy;

   assign i_req = |imem_rmask;
   assign d_req = (|dmem_rmask) | (|dmem_wmask);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= IDLE;
         starve_reg <= '0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         rmask_reg  <= '0;
         wmask_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         starve_reg <= starve_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         rmask_reg  <= rmask_next;
         wmask_reg  <= wmask_next;
      end
   end

   // Returning to IDLE on completion and sampling only there gives the
   // mandatory idle cycle between back-to-back grants for free.
   always_comb begin
      state_next  = state_reg;
      starve_next = starve_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      rmask_next  = rmask_reg;
      wmask_next  = wmask_reg;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (d_req && !(i_req && starve_reg == LIMIT)) begin
               grant_d = 1'b1;
            end else if (i_req) begin
               grant_i = 1'b1;
            end
            if (grant_d) begin
               state_next = DBUSY;
               addr_next  = dmem_addr;
               rmask_next = dmem_rmask;
               wmask_next = dmem_wmask;
               wdata_next = dmem_wdata;
               if (!i_req) begin
                  starve_next = '0;
               end else if (starve_reg != LIMIT) begin
                  starve_next = starve_reg + CW'(1);
               end
            end
            if (grant_i) begin
               state_next  = IBUSY;
               addr_next   = imem_addr;
               rmask_next  = imem_rmask;
               wmask_next  = '0;
               wdata_next  = '0;
               starve_next = '0;
            end
         end
         IBUSY: begin
            if (mem_resp) state_next = IDLE;
         end
         DBUSY: begin
            if (mem_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy      = (state_reg != IDLE);
   assign mem_addr  = busy ? addr_reg  : '0;
   assign mem_rmask = busy ? rmask_reg : '0;
   assign mem_wmask = busy ? wmask_reg : '0;
   assign mem_wdata = busy ? wdata_reg : '0;

   assign imem_resp  = (state_reg == IBUSY) && mem_resp;
   assign dmem_resp  = (state_reg == DBUSY) && mem_resp;
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives at the falling edge, samples 1 ns
// later, and compares against hand-computed values.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [3:0]  imem_rmask = '0;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr = '0;
   logic [3:0]  dmem_rmask = '0;
   logic [3:0]  dmem_wmask = '0;
   logic [31:0] dmem_wdata = '0;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_resp = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic fall();
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".rmask"}, {28'd0, mem_rmask}, 32'd0);
      check({tag, ".wmask"}, {28'd0, mem_wmask}, 32'd0);
      check({tag, ".addr"}, mem_addr, 32'd0);
      check({tag, ".wdata"}, mem_wdata, 32'd0);
      check({tag, ".resps"}, {30'd0, imem_resp, dmem_resp}, 32'd0);
   endtask

   initial begin
      // reset state
      fall(); fall();
      #1 check_idle("reset");
      fall(); rst = 1'b1;
      #1 check_idle("post_reset");
      $display("txn reset done");

      // fetch only, memory answers three cycles after the grant
      fall(); imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
      fall(); #1;
      check("fetch.rmask", {28'd0, mem_rmask}, 32'hF);
      check("fetch.addr", mem_addr, 32'h1eceb000);
      check("fetch.wmask", {28'd0, mem_wmask}, 32'd0);
      fall(); #1 check("fetch.hold_addr", mem_addr, 32'h1eceb000);
      fall(); mem_resp = 1'b1; mem_rdata = 32'h00000013;
      #1;
      check("fetch.iresp", {31'd0, imem_resp}, 32'd1);
      check("fetch.irdata", imem_rdata, 32'h00000013);
      check("fetch.dresp", {31'd0, dmem_resp}, 32'd0);
      fall(); mem_resp = 1'b0; imem_rmask = 4'h0;
      #1 check("fetch.iresp_pulse", {31'd0, imem_resp}, 32'd0);
      check("fetch.idle_rmask", {28'd0, mem_rmask}, 32'd0);
      $display("txn fetch-only done");

      // simultaneous fetch and load: data first, fetch after one idle cycle
      fall(); imem_addr = 32'h1eceb004; imem_rmask = 4'hF;
      dmem_addr = 32'h100; dmem_rmask = 4'h1;
      fall(); #1;
      check("both.first_addr", mem_addr, 32'h100);
      check("both.first_rmask", {28'd0, mem_rmask}, 32'h1);
      mem_resp = 1'b1; mem_rdata = 32'h000000aa;
      #1;
      check("both.dresp", {31'd0, dmem_resp}, 32'd1);
      check("both.drdata", dmem_rdata, 32'h000000aa);
      check("both.iresp", {31'd0, imem_resp}, 32'd0);
      fall(); mem_resp = 1'b0; dmem_rmask = 4'h0;
      #1 check("both.gap_rmask", {28'd0, mem_rmask}, 32'd0);
      fall(); #1;
      check("both.second_addr", mem_addr, 32'h1eceb004);
      check("both.second_rmask", {28'd0, mem_rmask}, 32'hF);
      mem_resp = 1'b1;
      #1 check("both.iresp2", {31'd0, imem_resp}, 32'd1);
      fall(); mem_resp = 1'b0; imem_rmask = 4'h0;
      $display("txn fetch+load done");

      // store with unaligned address, held until mem_resp
      fall(); dmem_addr = 32'h202; dmem_wmask = 4'h3; dmem_wdata = 32'hdeadbeef;
      fall(); #1;
      check("store.addr", mem_addr, 32'h202);
      check("store.wmask", {28'd0, mem_wmask}, 32'h3);
      check("store.rmask", {28'd0, mem_rmask}, 32'd0);
      check("store.wdata", mem_wdata, 32'hdeadbeef);
      fall(); #1;
      check("store.hold_wdata", mem_wdata, 32'hdeadbeef);
      check("store.no_resp", {31'd0, dmem_resp}, 32'd0);
      mem_resp = 1'b1;
      #1 check("store.dresp", {31'd0, dmem_resp}, 32'd1);
      fall(); mem_resp = 1'b0; dmem_wmask = 4'h0;
      #1 check("store.dresp_pulse", {31'd0, dmem_resp}, 32'd0);
      $display("txn store done");

      // read-modify request with both masks passes through unchanged
      fall(); dmem_addr = 32'h1234_5679; dmem_rmask = 4'h1; dmem_wmask = 4'h2;
      dmem_wdata = 32'h0000_5500;
      fall(); #1;
      check("rw.addr", mem_addr, 32'h1234_5679);
      check("rw.masks", {24'd0, mem_rmask, mem_wmask}, 32'h12);
      mem_resp = 1'b1;
      #1 check("rw.dresp", {31'd0, dmem_resp}, 32'd1);
      fall(); mem_resp = 1'b0; dmem_rmask = 4'h0; dmem_wmask = 4'h0;
      $display("txn rw done");

      // starvation: fetch held while data keeps coming; grant 5 must be fetch
      fall(); imem_addr = 32'h1eceb008; imem_rmask = 4'hF;
      dmem_addr = 32'h300; dmem_rmask = 4'hF;
      for (int g = 0; g < 5; g++) begin
         fall(); #1;
         if (g < 4) begin
            check($sformatf("starve.g%0d_addr", g), mem_addr, 32'h300 + 32'(4 * g));
         end else begin
            check("starve.g4_addr", mem_addr, 32'h1eceb008);
         end
         mem_resp = 1'b1;
         #1 check($sformatf("starve.g%0d_resps", g), {30'd0, imem_resp, dmem_resp},
                  (g < 4) ? 32'd1 : 32'd2);
         fall(); mem_resp = 1'b0;
         dmem_addr = 32'h300 + 32'(4 * (g + 1));
      end
      // counter cleared by the fetch grant: both pending again -> data wins
      fall(); #1 check("starve.after_addr", mem_addr, 32'h314);
      mem_resp = 1'b1;
      fall(); mem_resp = 1'b0; imem_rmask = 4'h0; dmem_rmask = 4'h0;
      $display("txn starvation done");

      // reset in DBUSY abandons the access; late mem_resp ignored
      fall(); dmem_addr = 32'h400; dmem_rmask = 4'hF;
      fall(); #1 check("rst.busy_rmask", {28'd0, mem_rmask}, 32'hF);
      #1 rst = 1'b0;
      #1;
      check_idle("rst.async");
      mem_resp = 1'b1;
      #1 check("rst.dresp_in_reset", {31'd0, dmem_resp}, 32'd0);
      fall(); mem_resp = 1'b0; dmem_rmask = 4'h0;
      fall(); rst = 1'b1;
      fall(); mem_resp = 1'b1;
      #1 check_idle("rst.late_resp");
      fall(); mem_resp = 1'b0;
      #1 check_idle("rst.after");
      $display("txn reset-mid-access done");

      // spurious mem_resp in IDLE
      fall(); mem_resp = 1'b1; mem_rdata = 32'hffff_ffff;
      #1 check_idle("spur.c0");
      fall(); #1 check_idle("spur.c1");
      fall(); mem_resp = 1'b0;
      imem_addr = 32'h0000_0040; imem_rmask = 4'h3;
      fall(); #1;
      check("spur.next_addr", mem_addr, 32'h40);
      check("spur.next_rmask", {28'd0, mem_rmask}, 32'h3);
      mem_resp = 1'b1;
      #1 check("spur.iresp", {31'd0, imem_resp}, 32'd1);
      fall(); mem_resp = 1'b0; imem_rmask = 4'h0;
      $display("txn spurious-resp done");

      fall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
